trigger_sequencer: RTL and testbench
====================================

# trigger_sequencer

Advanced-trigger sequencer that steps through up to 16 programmed trigger states, counts qualified hits per state, and decides when the capture fires. It sits directly upstream of the timer blocks. It drives their `update_timers` and start/clear/stop strobes and consumes their `timer_elapsed` flags as extra hit/else qualifiers. Its `run` output feeds the capture controller.

## Interface
Parameters:
- `NUM_STATES`, 16: number of sequence states; fixed at 16, the 4-bit state index.
- `OCC_WIDTH`, 20: width of each state's occurrence limit and its counter.

Ports:
- `clk`  in  1  system clock (100 MHz sample clock).
- `reset`  in  1  asynchronous, active-low reset.
- `wrenb`  in  1  configuration write strobe.
- `wraddr`  in  5  `[4:1]` state index, `[0]` word select.
- `config_data`  in  32  configuration word.
- `arm`  in  1  one-cycle pulse; starts the sequence at state 0.
- `sample_valid`  in  1  a new sample was evaluated this cycle.
- `hit_term`  in  1  hit condition of the current state, evaluated externally from `seq_state`.
- `else_term`  in  1  else condition of the current state.
- `timer_elapsed`  in  2  elapsed flags from timer 0 and timer 1.
- `update_timers`  out  1  qualifies the timer strobes.
- `fsm_start_timer`  out  2  per-timer start strobe.
- `fsm_clear_timer`  out  2  per-timer clear strobe.
- `fsm_stop_timer`  out  2  per-timer stop strobe.
- `run`  out  1  one-cycle trigger-fired pulse.
- `armed`  out  1  the sequence is active.
- `seq_state`  out  4  current state index.

## Operation
- Each state has two configuration words.
- Word 0 (`wraddr[0]=0`):
  - `[19:0]` occurrence limit; the state advances on hit number limit+1, so 0 means the first hit.
  - `[23:20]` else-target state.
  - `[24]` last-state flag.
  - `[26:25]` hit timer select: an elapsed selected timer counts as a hit.
  - `[28:27]` else timer select.
- Word 1 (`wraddr[0]=1`), each field is a 2-bit per-timer mask:
  - `[1:0]`, `[3:2]`, `[5:4]`: start, stop and clear masks applied on hit-advance.
  - `[7:6]`, `[9:8]`, `[11:10]`: start, stop and clear masks applied on else-jump.
- Qualifiers:
  - `hit_q = sample_valid & hit_term | |(hit_tsel & timer_elapsed)`.
  - `else_q = sample_valid & else_term | |(else_tsel & timer_elapsed)`.
- FSM states:
  - `IDLE`: reset value.
  - `ARMED`.
  - `FIRED`.
- `IDLE`/`FIRED` to `ARMED` on `arm`: `seq_state=0`, occurrence counter cleared.
- `ARMED`, `hit_q`, counter below limit: counter increments, no other effect.
- `ARMED`, `hit_q`, counter equal to limit:
  - Hit masks are applied and the counter is cleared.
  - If the last-state flag is set or `seq_state==15`, the FSM goes to `FIRED` and `run` pulses.
  - Otherwise `seq_state` increments.
- `ARMED`, `else_q` without `hit_q`: jump to the else-target, clear the counter, apply the else masks. An else-target equal to the current state also clears the counter.
- Hit has priority over else when both qualify.
- `arm` while `ARMED` restarts at state 0 and overrides any same-cycle hit or else.
- Counter arithmetic is unsigned and `OCC_WIDTH` bits wide, compared with `==`; it never wraps because it clears at the limit.
- Outside `ARMED`, all strobes and `update_timers` are 0.

## Timing
- Reset values: all outputs 0, FSM `IDLE`, counter 0.
- Configuration table: written on the `clk` edge with `wrenb`, not cleared by reset, and used by the next evaluation.
- Writes to the current state's entry while `ARMED` take effect on the following cycle.
- A hit or else decision in cycle N drives the following in cycle N+1, all for exactly one cycle:
  - `update_timers=1` together with the mask strobes.
  - The new `seq_state`.
  - `run`.
- `armed` rises the cycle after `arm` and falls the cycle `run` is asserted.
- A `timer_elapsed` flag held high keeps qualifying every cycle. Software clears the timer through the masks.
- Asserting `reset` mid-sequence forces `IDLE` asynchronously, clears all strobes immediately and leaves the table intact.

## Configuration
- `SEQ_TIMER1_EN`: when defined, both timers are supported.
- When undefined:
  - Bit 1 of every strobe output is tied to 0.
  - `timer_elapsed[1]` is ignored.
  - Timer-select bit 1 and mask bit 1 are stored but have no effect.
  - Timer 0 behaviour is unchanged.

## Structure
- Package `trigger_seq_pkg`:
  - FSM state enum.
  - Word-0/word-1 field offsets and widths.
  - `NUM_STATES`, `OCC_WIDTH` defaults.
  - Timer-mask bundle typedef.
- Sub-module `trigger_seq_table`: 16x2x32 register file with write port (`wrenb`/`wraddr`/`config_data`) and a combinational read of both words at `seq_state`.

## Test plan
- State 0 with limit 2, last-state flag; `arm` then 3 hits: `run` pulses exactly one cycle after the 3rd hit, and `seq_state` stays 0.
- State 0 with limit 0 and hit start-mask `01`; state 1 last with hit-timer-select `01`. One hit gives `update_timers=1` and `fsm_start_timer=01` the next cycle. Then raising `timer_elapsed[0]` fires `run` one cycle later.
- State 3 with else-target 1 and else clear-mask `11`; `hit_term=1` and `else_term=1` in the same cycle: hit wins, and the next state is 4.
- `else_term` only in state 3: `seq_state=1`, counter 0 and `fsm_clear_timer=11` in the same cycle.
- 16 states with limit 0 and no last flag; 16 hits: `run` fires on the hit in state 15.
- Assert `reset` low mid-sequence at state 5: outputs are 0 immediately. After release and `arm`, the sequence restarts at state 0 with the table preserved.
- Repeat the previous scenarios with `SEQ_TIMER1_EN` undefined: bit 1 of all strobes stays 0.

Source files
------------

// File: rtl/trigger_seq_pkg.sv
// trigger_seq_pkg: shared types, field offsets and defaults for the trigger sequencer
package trigger_seq_pkg;
    localparam int NUM_STATES_DEF = 16;
    localparam int OCC_WIDTH_DEF  = 20;
    localparam int W0_LIMIT_LSB   = 0;
    localparam int W0_ELSE_LSB    = 20;
    localparam int W0_ELSE_W      = 4;
    localparam int W0_LAST_BIT    = 24;
    localparam int W0_HTSEL_LSB   = 25;
    localparam int W0_ETSEL_LSB   = 27;
    localparam int TSEL_W         = 2;
    localparam int W1_HIT_LSB     = 0;
    localparam int W1_ELSE_LSB    = 6;
    localparam int MASK_BUNDLE_W  = 6;

    typedef enum logic [1:0] {IDLE, ARMED, FIRED} seq_fsm_e;

    // Field order matches word 1: start in [1:0], stop in [3:2], clear in [5:4].
    typedef struct packed {
        logic [1:0] clear;
        logic [1:0] stop;
        logic [1:0] start;
    } tmask_t;
endpackage

// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if: configuration, qualifier and timer-strobe bundle of the sequencer
interface trigger_sequencer_if;
    logic       wrenb;
    logic [4:0] wraddr;
    logic [31:0] config_data;
    logic       arm;
    logic       sample_valid;
    logic       hit_term;
    logic       else_term;
    logic [1:0] timer_elapsed;
    logic       update_timers;
    logic [1:0] fsm_start_timer;
    logic [1:0] fsm_clear_timer;
    logic [1:0] fsm_stop_timer;
    logic       run;
    logic       armed;
    logic [3:0] seq_state;

    modport master (
        output wrenb, wraddr, config_data, arm, sample_valid, hit_term, else_term, timer_elapsed,
        input  update_timers, fsm_start_timer, fsm_clear_timer, fsm_stop_timer, run, armed, seq_state
    );

    modport slave (
        input  wrenb, wraddr, config_data, arm, sample_valid, hit_term, else_term, timer_elapsed,
        output update_timers, fsm_start_timer, fsm_clear_timer, fsm_stop_timer, run, armed, seq_state
    );
endinterface

// File: rtl/trigger_seq_table.sv
// trigger_seq_table: per-state two-word configuration register file, read at the current state
module trigger_seq_table
    import trigger_seq_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF
) (
    input  logic        clk,
    input  logic        wrenb,
    input  logic [4:0]  wraddr,
    input  logic [31:0] config_data,
    input  logic [3:0]  rd_state,
    output logic [31:0] word0,
    output logic [31:0] word1
);
    logic [31:0] mem [0:NUM_STATES-1][0:1];

    // Table survives reset so software programs it once and re-arms freely.
    always_ff @(posedge clk)
        if (wrenb) mem[wraddr[4:1]][wraddr[0]] <= config_data;

    assign word0 = mem[rd_state][0];
    assign word1 = mem[rd_state][1];
endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: advanced-trigger state sequencer driving timer strobes and the capture run pulse
// SEQ_TIMER1_EN: define to enable timer 1; otherwise all timer-1 bits are masked off.
module trigger_sequencer
    import trigger_seq_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF,
    parameter int OCC_WIDTH  = OCC_WIDTH_DEF
) (
    input logic clk,
    input logic reset,
    trigger_sequencer_if.slave bus
);
`ifdef SEQ_TIMER1_EN
    localparam logic [1:0] TMR_EN = 2'b11;
`else
    localparam logic [1:0] TMR_EN = 2'b01;
`endif

    seq_fsm_e fsm_q, fsm_d;
    logic [3:0] state_q, state_d;
    logic [OCC_WIDTH-1:0] cnt_q, cnt_d;
    logic run_q, run_d, upd_q, upd_d;
    tmask_t mask_q, mask_d;
    logic [31:0] word0, word1;

    trigger_seq_table #(.NUM_STATES(NUM_STATES)) u_table (
        .clk(clk), .wrenb(bus.wrenb), .wraddr(bus.wraddr), .config_data(bus.config_data),
        .rd_state(state_q), .word0(word0), .word1(word1)
    );

    wire [OCC_WIDTH-1:0] limit = word0[W0_LIMIT_LSB +: OCC_WIDTH];
    wire [3:0] else_tgt = word0[W0_ELSE_LSB +: W0_ELSE_W];
    wire last_state = word0[W0_LAST_BIT];
    wire [1:0] hit_tsel = word0[W0_HTSEL_LSB +: TSEL_W];
    wire [1:0] else_tsel = word0[W0_ETSEL_LSB +: TSEL_W];
    wire tmask_t hit_m = tmask_t'(word1[W1_HIT_LSB +: MASK_BUNDLE_W]);
    wire tmask_t else_m = tmask_t'(word1[W1_ELSE_LSB +: MASK_BUNDLE_W]);
    wire [1:0] elapsed = bus.timer_elapsed & TMR_EN;
    wire hit_q = (bus.sample_valid & bus.hit_term) | (|(hit_tsel & elapsed));
    wire else_q = (bus.sample_valid & bus.else_term) | (|(else_tsel & elapsed));
    wire unused_word_bits = ^{word0[31:29], word1[31:12]};

    // State, counter and one-cycle strobes; strobes drop immediately on reset.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            upd_q   <= 1'b0;
            mask_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            upd_q   <= upd_d;
            mask_q  <= mask_d;
        end

    // Sequencing decision: arm overrides, hit beats else, strobes only from ARMED decisions.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = 1'b0;
        upd_d   = 1'b0;
        mask_d  = '0;
        if (bus.arm) begin
            fsm_d   = ARMED;
            state_d = '0;
            cnt_d   = '0;
        end else if (fsm_q == ARMED && hit_q) begin
            if (cnt_q == limit) begin
                cnt_d  = '0;
                upd_d  = 1'b1;
                mask_d = hit_m;
                if (last_state || state_q == 4'hf) begin
                    fsm_d = FIRED;
                    run_d = 1'b1;
                end else begin
                    state_d = state_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (fsm_q == ARMED && else_q) begin
            state_d = else_tgt;
            cnt_d   = '0;
            upd_d   = 1'b1;
            mask_d  = else_m;
        end
    end

    assign bus.update_timers   = upd_q;
    assign bus.fsm_start_timer = mask_q.start & TMR_EN;
    assign bus.fsm_stop_timer  = mask_q.stop & TMR_EN;
    assign bus.fsm_clear_timer = mask_q.clear & TMR_EN;
    assign bus.run             = run_q;
    assign bus.armed           = fsm_q == ARMED;
    assign bus.seq_state       = state_q;
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: directed self-checking bench for trigger_sequencer
module tb_trigger_sequencer;
`ifdef SEQ_TIMER1_EN
    localparam logic [1:0] ALL = 2'b11;
`else
    localparam logic [1:0] ALL = 2'b01;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    trigger_sequencer_if ifc ();

    trigger_sequencer dut (.clk(clk), .reset(reset), .bus(ifc.slave));

    always #5 clk = ~clk;

    task automatic cfg(input logic [3:0] idx, input logic [31:0] w0, input logic [31:0] w1);
        @(negedge clk);
        ifc.wrenb = 1'b1; ifc.wraddr = {idx, 1'b0}; ifc.config_data = w0;
        @(negedge clk);
        ifc.wraddr = {idx, 1'b1}; ifc.config_data = w1;
        @(negedge clk);
        ifc.wrenb = 1'b0;
    endtask

    // One decision cycle: drive at a falling edge, return at the next falling edge.
    task automatic step(input logic a, input logic h, input logic e, input logic [1:0] te);
        ifc.arm = a; ifc.sample_valid = h | e; ifc.hit_term = h; ifc.else_term = e; ifc.timer_elapsed = te;
        @(negedge clk);
        ifc.arm = 1'b0; ifc.sample_valid = 1'b0; ifc.hit_term = 1'b0; ifc.else_term = 1'b0; ifc.timer_elapsed = 2'b00;
    endtask

    task automatic test_reset();
        ifc.wrenb = 1'b0; ifc.wraddr = '0; ifc.config_data = '0;
        ifc.arm = 1'b0; ifc.sample_valid = 1'b0; ifc.hit_term = 1'b0; ifc.else_term = 1'b0; ifc.timer_elapsed = 2'b00;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifc.run !== 1'b0) begin errors++; $display("FAIL reset_run got %b exp 0", ifc.run); end
        checks++; if (ifc.armed !== 1'b0) begin errors++; $display("FAIL reset_armed got %b exp 0", ifc.armed); end
        checks++; if (ifc.seq_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", ifc.seq_state); end
        checks++; if (ifc.update_timers !== 1'b0) begin errors++; $display("FAIL reset_upd got %b exp 0", ifc.update_timers); end
        checks++; if ({ifc.fsm_start_timer, ifc.fsm_stop_timer, ifc.fsm_clear_timer} !== 6'd0) begin errors++; $display("FAIL reset_strobes got %b exp 0", {ifc.fsm_start_timer, ifc.fsm_stop_timer, ifc.fsm_clear_timer}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_occurrence();
        cfg(4'd0, 32'h0100_0002, 32'h0);
        step(1, 0, 0, 2'b00);
        checks++; if (ifc.armed !== 1'b1) begin errors++; $display("FAIL occ_armed got %b exp 1", ifc.armed); end
        step(0, 1, 0, 2'b00);
        step(0, 1, 0, 2'b00);
        checks++; if (ifc.run !== 1'b0) begin errors++; $display("FAIL occ_early_run got %b exp 0", ifc.run); end
        step(0, 1, 0, 2'b00);
        checks++; if (ifc.run !== 1'b1) begin errors++; $display("FAIL occ_run got %b exp 1", ifc.run); end
        checks++; if (ifc.armed !== 1'b0) begin errors++; $display("FAIL occ_armed_fall got %b exp 0", ifc.armed); end
        checks++; if (ifc.seq_state !== 4'd0) begin errors++; $display("FAIL occ_state got %0d exp 0", ifc.seq_state); end
        step(0, 0, 0, 2'b00);
        checks++; if (ifc.run !== 1'b0) begin errors++; $display("FAIL occ_run_pulse got %b exp 0", ifc.run); end
    endtask

    task automatic test_timer_qual();
        cfg(4'd0, 32'h0, 32'h1);
        cfg(4'd1, 32'h0300_0000, 32'h0);
        step(1, 0, 0, 2'b00);
        step(0, 1, 0, 2'b00);
        checks++; if (ifc.update_timers !== 1'b1) begin errors++; $display("FAIL tq_upd got %b exp 1", ifc.update_timers); end
        checks++; if (ifc.fsm_start_timer !== 2'b01) begin errors++; $display("FAIL tq_start got %b exp 01", ifc.fsm_start_timer); end
        checks++; if (ifc.seq_state !== 4'd1) begin errors++; $display("FAIL tq_state got %0d exp 1", ifc.seq_state); end
        step(0, 0, 0, 2'b01);
        checks++; if (ifc.run !== 1'b1) begin errors++; $display("FAIL tq_run got %b exp 1", ifc.run); end
        checks++; if (ifc.fsm_start_timer !== 2'b00) begin errors++; $display("FAIL tq_start_clr got %b exp 00", ifc.fsm_start_timer); end
    endtask

    task automatic test_hit_priority();
        for (int i = 0; i < 3; i++) cfg(4'(i), 32'h0, 32'h0);
        cfg(4'd3, 32'h0010_0001, 32'h0000_0C00);
        cfg(4'd4, 32'h0000_0005, 32'h0);
        step(1, 0, 0, 2'b00);
        repeat (3) step(0, 1, 0, 2'b00);
        checks++; if (ifc.seq_state !== 4'd3) begin errors++; $display("FAIL hp_reach got %0d exp 3", ifc.seq_state); end
        step(0, 1, 0, 2'b00);
        checks++; if (ifc.seq_state !== 4'd3 || ifc.update_timers !== 1'b0) begin errors++; $display("FAIL hp_count got state %0d upd %b exp 3/0", ifc.seq_state, ifc.update_timers); end
        step(0, 1, 1, 2'b00);
        checks++; if (ifc.seq_state !== 4'd4) begin errors++; $display("FAIL hp_state got %0d exp 4", ifc.seq_state); end
        checks++; if (ifc.fsm_clear_timer !== 2'b00) begin errors++; $display("FAIL hp_clear got %b exp 00", ifc.fsm_clear_timer); end
    endtask

    task automatic test_else_jump();
        step(1, 0, 0, 2'b00);
        repeat (4) step(0, 1, 0, 2'b00);
        step(0, 0, 1, 2'b00);
        checks++; if (ifc.seq_state !== 4'd1) begin errors++; $display("FAIL ej_state got %0d exp 1", ifc.seq_state); end
        checks++; if (ifc.fsm_clear_timer !== ALL) begin errors++; $display("FAIL ej_clear got %b exp %b", ifc.fsm_clear_timer, ALL); end
        checks++; if (ifc.update_timers !== 1'b1) begin errors++; $display("FAIL ej_upd got %b exp 1", ifc.update_timers); end
        step(0, 1, 0, 2'b00);
        checks++; if (ifc.seq_state !== 4'd2) begin errors++; $display("FAIL ej_cnt_clear got %0d exp 2", ifc.seq_state); end
    endtask

    task automatic test_sixteen();
        for (int i = 0; i < 16; i++) cfg(4'(i), 32'h0, (i == 4) ? 32'h1 : 32'h0);
        step(1, 0, 0, 2'b00);
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 0, 2'b00);
            checks++; if (ifc.seq_state !== 4'(i) || ifc.run !== 1'b0) begin errors++; $display("FAIL s16_walk got state %0d run %b exp %0d/0", ifc.seq_state, ifc.run, i); end
        end
        step(0, 1, 0, 2'b00);
        checks++; if (ifc.run !== 1'b1 || ifc.seq_state !== 4'd15) begin errors++; $display("FAIL s16_fire got run %b state %0d exp 1/15", ifc.run, ifc.seq_state); end
    endtask

    task automatic test_arm_override();
        step(1, 0, 0, 2'b00);
        repeat (2) step(0, 1, 0, 2'b00);
        step(1, 1, 0, 2'b00);
        checks++; if (ifc.seq_state !== 4'd0 || ifc.update_timers !== 1'b0 || ifc.armed !== 1'b1) begin errors++; $display("FAIL arm_ovr got state %0d upd %b armed %b exp 0/0/1", ifc.seq_state, ifc.update_timers, ifc.armed); end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 2'b00);
        repeat (5) step(0, 1, 0, 2'b00);
        checks++; if (ifc.seq_state !== 4'd5 || ifc.fsm_start_timer !== 2'b01) begin errors++; $display("FAIL rm_pre got state %0d start %b exp 5/01", ifc.seq_state, ifc.fsm_start_timer); end
        reset = 1'b0;
        #1;
        checks++; if ({ifc.update_timers, ifc.fsm_start_timer, ifc.armed, ifc.run, ifc.seq_state} !== 9'd0) begin errors++; $display("FAIL rm_async got %b exp 0", {ifc.update_timers, ifc.fsm_start_timer, ifc.armed, ifc.run, ifc.seq_state}); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        step(1, 0, 0, 2'b00);
        checks++; if (ifc.seq_state !== 4'd0 || ifc.armed !== 1'b1) begin errors++; $display("FAIL rm_rearm got state %0d armed %b exp 0/1", ifc.seq_state, ifc.armed); end
        repeat (5) step(0, 1, 0, 2'b00);
        checks++; if (ifc.seq_state !== 4'd5 || ifc.fsm_start_timer !== 2'b01) begin errors++; $display("FAIL rm_table got state %0d start %b exp 5/01", ifc.seq_state, ifc.fsm_start_timer); end
    endtask

    task automatic test_timer1();
        cfg(4'd0, 32'h0500_0000, 32'h0000_003F);
        step(1, 0, 0, 2'b00);
        step(0, 0, 0, 2'b10);
`ifdef SEQ_TIMER1_EN
        checks++; if (ifc.run !== 1'b1) begin errors++; $display("FAIL t1_run got %b exp 1", ifc.run); end
        checks++; if (ifc.fsm_stop_timer !== 2'b11) begin errors++; $display("FAIL t1_stop got %b exp 11", ifc.fsm_stop_timer); end
`else
        checks++; if (ifc.run !== 1'b0 || ifc.update_timers !== 1'b0) begin errors++; $display("FAIL t1_ignored got run %b upd %b exp 0/0", ifc.run, ifc.update_timers); end
        step(0, 1, 0, 2'b10);
        checks++; if (ifc.run !== 1'b1) begin errors++; $display("FAIL t1_run got %b exp 1", ifc.run); end
        checks++; if ({ifc.fsm_start_timer, ifc.fsm_stop_timer, ifc.fsm_clear_timer} !== 6'b01_01_01) begin errors++; $display("FAIL t1_bit1 got %b exp 010101", {ifc.fsm_start_timer, ifc.fsm_stop_timer, ifc.fsm_clear_timer}); end
`endif
    endtask

    initial begin
        test_reset();
        test_occurrence();
        test_timer_qual();
        test_hit_priority();
        test_else_jump();
        test_sixteen();
        test_arm_override();
        test_reset_mid();
        test_timer1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
